// File: rtl/byte_pack_pkg.sv
// byte_pack_pkg: shared constants and types for the byte-to-word packer.
package byte_pack_pkg;
    localparam int DEF_BYTE_W = 8;
    localparam int DEF_LANES = 4;
    localparam int LANE_W = $clog2(DEF_LANES);
    typedef logic [LANE_W-1:0] lane_t;
    localparam logic [DEF_LANES-1:0] MASK_ALL = '1;
endpackage

// File: rtl/byte_word_packer_if.sv
// byte_word_packer_if: byte input and word output handshakes of the packer.
// in_last exists only when PACK_FLUSH_EN is defined.
interface byte_word_packer_if
    import byte_pack_pkg::*;
#(
    parameter int BYTE_W = DEF_BYTE_W,
    parameter int LANES = DEF_LANES
);
    logic in_valid;
    logic in_ready;
    logic [BYTE_W-1:0] in_byte;
`ifdef PACK_FLUSH_EN
    logic in_last;
`endif
    logic out_valid;
    logic out_ready;
    logic [LANES*BYTE_W-1:0] out_word;
    logic [LANES-1:0] out_mask;

    modport master (
        output in_valid, in_byte, out_ready,
`ifdef PACK_FLUSH_EN
        output in_last,
`endif
        input in_ready, out_valid, out_word, out_mask
    );

    modport slave (
        input in_valid, in_byte, out_ready,
`ifdef PACK_FLUSH_EN
        input in_last,
`endif
        output in_ready, out_valid, out_word, out_mask
    );
endinterface

// File: rtl/lane_onehot_decoder.sv
// lane_onehot_decoder: turns the lane counter and accept strobe into one-hot lane write enables.
module lane_onehot_decoder #(
    parameter int LANES = 4
) (
    input  logic [$clog2(LANES)-1:0] idx,
    input  logic                     en,
    output logic [LANES-1:0]         we
);
    always_comb we = en ? ({{(LANES-1){1'b0}}, 1'b1} << idx) : '0;
endmodule

// File: rtl/byte_word_packer.sv
// byte_word_packer: packs LANES consecutive bytes into one word, lane 0 in the LSB.
// Optional PACK_FLUSH_EN adds in_last to complete a word early with a partial mask.
module byte_word_packer
    import byte_pack_pkg::*;
#(
    parameter int BYTE_W = DEF_BYTE_W,
    parameter int LANES = DEF_LANES
) (
    input logic clk,
    input logic rst_n,
    byte_word_packer_if.slave bus
);
    localparam int LW = $clog2(LANES);
    localparam int WW = LANES * BYTE_W;

    logic [LW-1:0] cnt;
    logic [WW-1:0] asm_word, merged_word, word_q;
    logic [LANES-1:0] asm_mask, we, done_mask, mask_q;
    logic valid_q, accept, completing, stall;

`ifdef PACK_FLUSH_EN
    assign completing = (cnt == LW'(LANES-1)) || bus.in_last;
`else
    assign completing = cnt == LW'(LANES-1);
`endif
    // Only a completing byte needs the output slot, so partial bytes keep flowing under stall.
    assign stall = valid_q && !bus.out_ready;
    assign bus.in_ready = rst_n && !(completing && stall);
    assign accept = bus.in_valid && bus.in_ready;

    lane_onehot_decoder #(.LANES(LANES)) u_dec (
        .idx(cnt),
        .en (accept),
        .we (we)
    );

    always_comb begin
        merged_word = asm_word;
        for (int i = 0; i < LANES; i++)
            if (we[i]) merged_word[i*BYTE_W +: BYTE_W] = bus.in_byte;
    end

    assign done_mask = asm_mask | we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            asm_word <= '0;
            asm_mask <= '0;
            word_q <= '0;
            mask_q <= '0;
            valid_q <= 1'b0;
        end else if (accept && completing) begin
            word_q <= merged_word;
            mask_q <= done_mask;
            valid_q <= 1'b1;
            cnt <= '0;
            asm_word <= '0;
            asm_mask <= '0;
        end else begin
            if (accept) begin
                asm_word <= merged_word;
                asm_mask <= done_mask;
                cnt <= cnt + 1'b1;
            end
            if (bus.out_ready) valid_q <= 1'b0;
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.out_word = word_q;
    assign bus.out_mask = mask_q;
endmodule

// File: doc/byte_word_packer.md
# byte_word_packer

Sequential byte-to-word assembler for the register-file datapath. Accepts one byte per cycle over a valid/ready handshake and packs LANES consecutive bytes into one word, lane 0 in the least-significant byte. It feeds byte-wide sources, such as a serial loader or byte memory port, into 32-bit register writes. It is the write-side counterpart of the existing combinational word-to-byte split.

## Interface
- BYTE_W, 8, width of one byte lane
- LANES, 4, bytes per output word; power of two, at least 2
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_byte is valid this cycle
- in_ready  output  1  packer accepts in_byte this cycle
- in_byte  input  BYTE_W  incoming byte
- in_last  input  1  accepted byte ends the word early; present only with PACK_FLUSH_EN
- out_valid  output  1  out_word holds a completed word
- out_ready  input  1  consumer takes out_word this cycle
- out_word  output  LANES*BYTE_W  packed word; lane i at bits [(i+1)*BYTE_W-1 : i*BYTE_W]
- out_mask  output  LANES  lanes carrying valid data in out_word

Clock and reset are fixed: one clock, clk; reset rst_n, asynchronous, active-low.

## Operation
- Byte accepted on a cycle with in_valid && in_ready.
- State:
  - lane counter cnt, 0..LANES-1
  - assembly register asm_word with per-lane fill mask asm_mask
  - output holding register (out_word, out_mask, out_valid)
- An accepted byte is written into lane cnt of asm_word and sets asm_mask[cnt].
- Non-completing byte (cnt != LANES-1, and no in_last): cnt increments.
- Completing byte (cnt == LANES-1, or in_last with PACK_FLUSH_EN):
  - the assembled word is transferred to the output register, with the current byte merged in the same edge
  - out_mask is set from the fill mask; unfilled lanes read zero
  - cnt returns to 0; asm_word and asm_mask clear
- in_ready = rst_n && (cnt != LANES-1 || !out_valid || out_ready). With PACK_FLUSH_EN, the in_last case is also gated on !out_valid || out_ready.
- in_ready depends combinationally on out_ready. No other combinational input-to-output paths.
- Output drain: out_valid clears on out_ready unless a completing byte is loaded on the same edge.
- Non-completing bytes are always accepted, even while the output is stalled, so the packer buffers up to LANES-1 bytes ahead.

## Timing
- Reset values:
  - out_valid=0, out_word=0, out_mask=0, cnt=0, asm_word=0, asm_mask=0
  - in_ready=0 while rst_n is low, 1 in the first cycle after release
- Latency: completing byte accepted at edge k; out_valid is high in the cycle after edge k.
- Throughput: one byte per cycle sustained when out_ready is held high. One word every LANES cycles, with no bubbles.
- Simultaneous completion and drain: the old word leaves, the new word loads, and out_valid stays 1.
- Output stalled with cnt == LANES-1: in_ready=0 and the byte is held off. No data is lost or overwritten.
- out_word and out_mask stay stable while out_valid && !out_ready.
- Reset asserted mid-word: the partial word and any pending output are discarded immediately.

## Configuration
- PACK_FLUSH_EN
- Defined:
  - the in_last port exists
  - an accepted byte with in_last=1 completes the word at any lane
  - out_mask marks lanes 0..cnt; higher lanes are zero
  - in_last on lane LANES-1 behaves like a normal completion
- Undefined:
  - no in_last port
  - words complete only at lane LANES-1
  - out_mask is all-ones whenever out_valid is high, and 0 after reset

## Structure
- Shared package byte_pack_pkg holds:
  - default BYTE_W and LANES constants
  - lane index typedef, $clog2(LANES) bits
  - all-ones mask constant
- One sub-module, lane_onehot_decoder: converts cnt plus the accept strobe into a one-hot per-lane write enable.
- Counter, registers and handshake logic live in the top module.

## Test plan
- Reset: hold rst_n low 3 cycles, then release → out_valid=0, out_word=0, out_mask=0; in_ready=0 during reset and 1 after.
- Streaming: send bytes 0x11,0x22,0x33,0x44,0x55… with out_ready=1 → out_word=0x44332211 with out_mask=4'hF one cycle after the 0x44 accept, then 0x88776655; no in_ready deassertion.
- Backpressure: hold out_ready=0 after the first word, send 0xA1..0xA4 → 0xA1..0xA3 accepted, in_ready=0 at 0xA4. Raise out_ready → first word drains, 0xA4 is accepted on the same edge, and out_word=0xA4A3A2A1 in the next cycle.
- Flush (PACK_FLUSH_EN): send 0xDE then 0xAD with in_last=1 → out_word=0x0000ADDE, out_mask=4'b0011. The next word starts at lane 0.
- Reset mid-word: accept 0x01,0x02, pulse rst_n low, then send 0x10,0x20,0x30,0x40 → out_word=0x40302010; no 0x01 or 0x02 appears.
- Random valid/ready stress: 1000 random bytes with random stalls; scoreboard confirms byte order, lane placement and mask, with no loss or duplication.
